fifo_write_arbiter: RTL

//  Shares the write port of asynchronous_fifo among NUM_REQ requesters in the trans_clk domain.

---
 rtl/fifo_write_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter with burst hold, feeding the asynchronous_fifo write side.
// Define FIFO_ARB_PRIO_EN to give requester 0 strict priority at every IDLE arbitration.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                        trans_clk,
  input  logic                        trans_rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  input  logic                        fifo_full,
  output logic                        write_enable,
  output logic [DATA_W-1:0]           trans_data,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

`ifdef FIFO_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t            st, st_n;
  logic [ID_W-1:0]   owner, owner_n;
  logic [ID_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [ID_W-1:0]   rel_ptr, arb_base, arb_idx, g;
  logic              arb_valid, gv, accept;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + (ID_W+1)'(k);
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    return sum[ID_W-1:0];
  endfunction

  // A priority win by requester 0 leaves the round-robin pointer untouched.
  assign rel_ptr  = (PRIO_EN && owner == '0) ? ptr : owner;
  assign arb_base = (st == BURST) ? rel_ptr : ptr;
  assign cnt_inc  = cnt + CNT_W'(1);

  // Search base+1, base+2, ...; descending loop so the nearest requester wins.
  always_comb begin
    arb_valid = |req;
    arb_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[wrap_add(arb_base, k)]) arb_idx = wrap_add(arb_base, k);
    end
    if (PRIO_EN && req[0]) arb_idx = '0;
  end

  always_comb begin
    st_n    = st;
    owner_n = owner;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gv      = 1'b0;
    g       = '0;
    accept  = 1'b0;
    case (st)
      IDLE: begin
        gv     = arb_valid;
        g      = arb_idx;
        accept = gv & ~fifo_full & trans_rst;
        if (accept) begin
          if (BURST_LEN == 1) begin
            ptr_n = (PRIO_EN && g == '0) ? ptr : g;
          end else begin
            st_n    = BURST;
            owner_n = g;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      BURST: begin
        if (req[owner]) begin
          gv     = 1'b1;
          g      = owner;
          accept = ~fifo_full & trans_rst;
          if (accept) begin
            if (cnt_inc == CNT_W'(BURST_LEN)) begin
              st_n  = IDLE;
              cnt_n = '0;
              ptr_n = rel_ptr;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        end else begin
          // Owner dropped out: close the burst and hand the port over without a bubble.
          st_n   = IDLE;
          cnt_n  = '0;
          ptr_n  = rel_ptr;
          gv     = arb_valid;
          g      = arb_idx;
          accept = gv & ~fifo_full & trans_rst;
          if (accept && BURST_LEN > 1) begin
            st_n    = BURST;
            owner_n = g;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge trans_clk or negedge trans_rst) begin
    if (!trans_rst) begin
      st    <= IDLE;
      owner <= '0;
      cnt   <= '0;
      ptr   <= ID_W'(NUM_REQ - 1);
    end else begin
      st    <= st_n;
      owner <= owner_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
    end
  end

  assign write_enable = accept;
  assign ack          = accept ? (NUM_REQ'(1) << g) : '0;
  assign trans_data   = accept ? req_data[g*DATA_W +: DATA_W] : '0;
  assign grant_id     = trans_rst ? g : '0;
  assign busy         = trans_rst & (st == BURST);

endmodule
